// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with load-use hazard detection, jump flush and
// saturating stall/flush performance counters.
module if_id_hazard #(
  parameter int          CNT_W = 16,
  parameter logic [31:0] NOP   = 32'h00000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      I_Next_address,
  input  logic [31:0]      I_Instr,
  input  logic             I_IDEX_MemRead,
  input  logic [4:0]       I_IDEX_RT,
  input  logic             I_Flush,
  input  logic             I_Clr_Cnt,
  output logic [31:0]      O_Next_address,
  output logic [31:0]      O_Instr,
  output logic             O_Valid,
  output logic             O_PC_Write,
  output logic             O_Bubble,
  output logic [CNT_W-1:0] O_Stall_Cnt,
  output logic [CNT_W-1:0] O_Flush_Cnt
);

  localparam logic [5:0]       OP_J    = 6'b000010;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0]      instr_q, instr_d;
  logic [31:0]      naddr_q, naddr_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [5:0] op;
  logic [4:0] rs, rt;
  logic       hazard, stall;

  assign op = instr_q[31:26];
  assign rs = instr_q[25:21];
  assign rt = instr_q[20:16];

  // Jumps carry a target, not registers, in [25:16], so they never match.
  assign hazard = valid_q & I_IDEX_MemRead & (I_IDEX_RT != 5'd0) & (op != OP_J) &
                  ((rs == I_IDEX_RT) | (rt == I_IDEX_RT));
  assign stall  = hazard & ~I_Flush;

  assign O_PC_Write = ~stall;
  assign O_Bubble   = I_Flush | stall;

  always_comb begin
    instr_d = I_Instr;
    naddr_d = I_Next_address;
    valid_d = 1'b1;
    if (I_Flush) begin
      instr_d = NOP;
      naddr_d = 32'd0;
      valid_d = 1'b0;
    end else if (stall) begin
      instr_d = instr_q;
      naddr_d = naddr_q;
      valid_d = valid_q;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (I_Clr_Cnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall && stall_cnt_q != CNT_MAX)   stall_cnt_d = stall_cnt_q + 1'b1;
      if (I_Flush && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q     <= NOP;
      naddr_q     <= 32'd0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      instr_q     <= instr_d;
      naddr_q     <= naddr_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign O_Instr        = instr_q;
  assign O_Next_address = naddr_q;
  assign O_Valid        = valid_q;
  assign O_Stall_Cnt    = stall_cnt_q;
  assign O_Flush_Cnt    = flush_cnt_q;

endmodule

// File: tb/tb_if_id_hazard.sv
// Directed plus randomized bench for if_id_hazard against a behavioural model.
module tb_if_id_hazard;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      I_Next_address, I_Instr;
  logic             I_IDEX_MemRead, I_Flush, I_Clr_Cnt;
  logic [4:0]       I_IDEX_RT;
  logic [31:0]      O_Next_address, O_Instr;
  logic             O_Valid, O_PC_Write, O_Bubble;
  logic [CNT_W-1:0] O_Stall_Cnt, O_Flush_Cnt;

  int checks = 0, errors = 0;

  bit [31:0] m_instr, m_addr;
  bit        m_valid;
  int        m_scnt, m_fcnt;
  localparam int CMAX = (1 << CNT_W) - 1;

  if_id_hazard #(.CNT_W(CNT_W), .NOP(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .I_Next_address(I_Next_address), .I_Instr(I_Instr),
    .I_IDEX_MemRead(I_IDEX_MemRead), .I_IDEX_RT(I_IDEX_RT),
    .I_Flush(I_Flush), .I_Clr_Cnt(I_Clr_Cnt),
    .O_Next_address(O_Next_address), .O_Instr(O_Instr), .O_Valid(O_Valid),
    .O_PC_Write(O_PC_Write), .O_Bubble(O_Bubble),
    .O_Stall_Cnt(O_Stall_Cnt), .O_Flush_Cnt(O_Flush_Cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit model_hz(input bit mr, input int rt);
    int op, rs, rtf;
    op  = int'(m_instr >> 26);
    rs  = int'((m_instr >> 21) & 32'd31);
    rtf = int'((m_instr >> 16) & 32'd31);
    return m_valid && mr && rt != 0 && op != 2 && (rs == rt || rtf == rt);
  endfunction

  task automatic model_reset();
    m_instr = 0; m_addr = 0; m_valid = 0; m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".instr"}, O_Instr, m_instr);
    chk({tag, ".addr"},  O_Next_address, m_addr);
    chk({tag, ".valid"}, {31'd0, O_Valid}, {31'd0, m_valid});
    chk({tag, ".scnt"},  {28'd0, O_Stall_Cnt}, m_scnt);
    chk({tag, ".fcnt"},  {28'd0, O_Flush_Cnt}, m_fcnt);
  endtask

  // Enter and leave 1 time unit after a rising edge.
  task automatic cyc(input bit [31:0] ins, input bit [31:0] adr, input bit mr,
                     input bit [4:0] rt, input bit fl, input bit clr);
    bit hz, st;
    I_Instr = ins; I_Next_address = adr; I_IDEX_MemRead = mr;
    I_IDEX_RT = rt; I_Flush = fl; I_Clr_Cnt = clr;
    #2;
    hz = model_hz(mr, int'(rt));
    st = hz && !fl;
    chk("pc_write", {31'd0, O_PC_Write}, {31'd0, !st});
    chk("bubble",   {31'd0, O_Bubble},   {31'd0, fl || st});
    @(posedge clk);
    if (fl) begin
      m_instr = 0; m_addr = 0; m_valid = 0;
    end else if (!st) begin
      m_instr = ins; m_addr = adr; m_valid = 1;
    end
    if (clr) begin
      m_scnt = 0; m_fcnt = 0;
    end else begin
      if (st && m_scnt < CMAX) m_scnt++;
      if (fl && m_fcnt < CMAX) m_fcnt++;
    end
    #1;
    check_regs("reg");
  endtask

  initial begin
    bit [5:0] op;
    bit [4:0] rs, rt, irt;
    rst_n = 1'b0;
    I_Instr = 0; I_Next_address = 0; I_IDEX_MemRead = 0;
    I_IDEX_RT = 0; I_Flush = 0; I_Clr_Cnt = 0;
    model_reset();
    #3;
    check_regs("reset");
    chk("reset.pc_write", {31'd0, O_PC_Write}, 32'd1);
    chk("reset.bubble",   {31'd0, O_Bubble},   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // reset then run
    cyc(32'h8C220004, 32'd4, 0, 0, 0, 0);
    chk("t1.instr", O_Instr, 32'h8C220004);
    chk("t1.valid", {31'd0, O_Valid}, 32'd1);
    // load-use on rs
    cyc(32'h00441820, 32'd8, 0, 0, 0, 0);
    cyc(32'h11111111, 32'd12, 1, 2, 0, 0);
    chk("t2.hold", O_Instr, 32'h00441820);
    chk("t2.scnt", {28'd0, O_Stall_Cnt}, 32'd1);
    cyc(32'h11111111, 32'd12, 0, 0, 0, 0);
    // $zero and jump never stall
    cyc(32'h00401820, 32'd16, 0, 0, 0, 0);
    cyc(32'h08420000, 32'd20, 1, 0, 0, 0);
    cyc(32'h00000000, 32'd24, 1, 2, 0, 0);
    chk("t3.jump_no_stall", O_Instr, 32'h00000000);
    // flush, then flush colliding with a hazard
    cyc(32'h00441820, 32'd28, 0, 0, 1, 0);
    chk("t4.fcnt", {28'd0, O_Flush_Cnt}, 32'd1);
    cyc(32'h00441820, 32'd32, 0, 0, 0, 0);
    cyc(32'h22222222, 32'd36, 1, 2, 1, 0);
    chk("t4.scnt", {28'd0, O_Stall_Cnt}, 32'd1);
    // saturation and clear under a persistent hazard
    cyc(32'h00441820, 32'd40, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(32'h33333333, 32'd44, 1, 2, 0, 0);
    chk("t5.sat", {28'd0, O_Stall_Cnt}, 32'd15);
    cyc(32'h33333333, 32'd44, 1, 2, 0, 1);
    chk("t5.clr", {28'd0, O_Stall_Cnt}, 32'd0);
    // async reset between edges while stalling
    cyc(32'h33333333, 32'd44, 1, 2, 0, 0);
    #2;
    chk("t6.stalling", {31'd0, O_PC_Write}, 32'd0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("t6");
    chk("t6.pc_write", {31'd0, O_PC_Write}, 32'd1);
    chk("t6.bubble",   {31'd0, O_Bubble},   32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    I_IDEX_MemRead = 0;

    // randomized traffic with colliding register fields
    for (int i = 0; i < 400; i++) begin
      op  = ($urandom_range(0, 3) == 0) ? 6'b000010 : 6'($urandom);
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      irt = 5'($urandom_range(0, 3));
      cyc({op, rs, rt, 16'($urandom)}, $urandom, 1'($urandom_range(0, 1)), irt,
          $urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_id_hazard.md
# if_id_hazard

Front-end pipeline register plus load-use hazard unit of the 32-bit MIPS pipeline. It sits between the fetch stage and the ID/EX buffer. It latches the fetched instruction and its next address into the IF/ID register. It stalls PC and IF/ID on a load-use dependency, flushes wrong-path work when a jump resolves in EX, and keeps saturating stall/flush performance counters.

## Interface
Parameters:
- CNT_W, 16, width of stall and flush counters.
- NOP, 32'h00000000, instruction word loaded on flush and reset.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- I_Next_address  in  32  PC+4 from fetch.
- I_Instr  in  32  fetched instruction word.
- I_IDEX_MemRead  in  1  MemRead control bit currently held in ID/EX.
- I_IDEX_RT  in  5  destination RT currently held in ID/EX.
- I_Flush  in  1  jump taken in EX (ID/EX jump output); kills IF and ID.
- I_Clr_Cnt  in  1  synchronous clear of both counters.
- O_Next_address  out  32  IF/ID latched PC+4.
- O_Instr  out  32  IF/ID latched instruction.
- O_Valid  out  1  IF/ID holds a real instruction.
- O_PC_Write  out  1  PC register load enable (combinational).
- O_Bubble  out  1  force zero WB/M/EX controls into ID/EX this cycle (combinational).
- O_Stall_Cnt  out  CNT_W  cycles stalled, saturating.
- O_Flush_Cnt  out  CNT_W  flush events, saturating.

## Operation
- Fields: rs = O_Instr[25:21], rt = O_Instr[20:16], op = O_Instr[31:26].
- Hazard is combinational: hazard = O_Valid & I_IDEX_MemRead & (I_IDEX_RT != 0) & (op != 6'b000010) & ((rs == I_IDEX_RT) | (rt == I_IDEX_RT)).
- Priority per cycle: flush > stall > normal.
  - Flush (I_Flush=1):
    - IF/ID loads NOP, O_Valid<=0, O_Next_address<=0.
    - O_PC_Write=1, so the external mux loads the jump target.
    - O_Bubble=1.
    - O_Flush_Cnt increments.
  - Stall (hazard & ~I_Flush):
    - IF/ID holds all fields.
    - O_PC_Write=0.
    - O_Bubble=1.
    - O_Stall_Cnt increments.
  - Normal:
    - IF/ID loads I_Instr and I_Next_address, O_Valid<=1.
    - O_PC_Write=1.
    - O_Bubble=0.
- A stall lasts exactly one cycle per load. The next cycle ID/EX holds a bubble (MemRead=0), so the hazard clears without internal state.
- Counters:
  - Saturate at all-ones and never wrap.
  - I_Clr_Cnt has priority over increment in the same cycle; the counter becomes 0.
- O_Valid=0 suppresses hazard detection (a NOP in IF/ID never stalls).

## Timing
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - O_Instr=NOP, O_Next_address=0, O_Valid=0.
  - O_Stall_Cnt=0, O_Flush_Cnt=0.
  - O_PC_Write=1 and O_Bubble=0, since these follow from the reset state.
- Release: the first rising edge with rst_n=1 loads the fetch inputs.
- IF/ID latency is 1 cycle: fetch inputs on edge N appear on the outputs after edge N.
- O_PC_Write and O_Bubble are valid in the same cycle as the hazard/flush condition and must settle before the next edge.
- Reset asserted mid-stall or mid-flush aborts the operation. Counters do not count the aborted cycle.
- Flush and hazard in the same cycle: the flush wins and counts only as a flush, not as a stall.

## Test plan
1. Reset then run: rst_n low → O_Instr=0, O_Valid=0, counters 0. Release and feed I_Instr=32'h8C220004 / addr 4 → next cycle O_Instr=32'h8C220004, O_Next_address=4, O_Valid=1.
2. Load-use on rs: ID/EX MemRead=1, RT=2; IF/ID holds add $3,$2,$4 (32'h00441820) → O_PC_Write=0, O_Bubble=1, IF/ID unchanged one cycle, O_Stall_Cnt=1. Drop MemRead → normal load resumes.
3. No stall for $zero or jump: RT=0 with matching rs → no stall. Jump opcode 000010 whose [25:16] bits match RT → no stall.
4. Flush: I_Flush=1 while IF/ID valid → next cycle O_Instr=0, O_Valid=0, O_Bubble=1 in the flush cycle, O_Flush_Cnt=1. Flush together with hazard → O_PC_Write=1, O_Stall_Cnt unchanged.
5. Saturation and clear: with CNT_W=4, hold the hazard 20 cycles → O_Stall_Cnt=15. Pulse I_Clr_Cnt while the hazard persists → 0.
6. Async reset mid-stall: drop rst_n between edges while stalling → outputs go to reset values before the next edge.
